// File: rtl/bufg_gt_div_ctrl_pkg.sv
// Shared types and helpers for the GT clock-buffer divide sequencer.
package bufg_gt_div_ctrl_pkg;

  localparam int unsigned DIV_W   = 3;
  localparam int unsigned RATIO_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GATE    = 3'd1,
    CLEAR   = 3'd2,
    SETDIV  = 3'd3,
    RELEASE = 3'd4,
    ENABLE  = 3'd5
  } state_t;

  localparam logic [DIV_W-1:0] DIV_1 = 3'b000;
  localparam logic [DIV_W-1:0] DIV_2 = 3'b001;
  localparam logic [DIV_W-1:0] DIV_3 = 3'b010;
  localparam logic [DIV_W-1:0] DIV_4 = 3'b011;
  localparam logic [DIV_W-1:0] DIV_5 = 3'b100;
  localparam logic [DIV_W-1:0] DIV_6 = 3'b101;
  localparam logic [DIV_W-1:0] DIV_7 = 3'b110;
  localparam logic [DIV_W-1:0] DIV_8 = 3'b111;

  // Divide code to ratio; zero-extended so 3'b111 maps to 8 without wrapping.
  function automatic logic [RATIO_W-1:0] div2ratio(input logic [DIV_W-1:0] code);
    return RATIO_W'({1'b0, code}) + RATIO_W'(1);
  endfunction

endpackage

// File: rtl/bufg_gt_ctrl_timer.sv
// Down-counting wait timer shared by all timed sequencer states.
module bufg_gt_ctrl_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Reset is delivered as a load from the owner, so no separate reset input.
  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/bufg_gt_div_ctrl.sv
// Glitch-free divide-change sequencer for a GT clock buffer (gate, clear, set DIV, release, enable).
// Optional BUFG_GT_DIV_CTRL_STATS_EN adds cfg_count and err_sticky.
module bufg_gt_div_ctrl
  import bufg_gt_div_ctrl_pkg::*;
#(
  parameter logic [2:0]  INIT_DIV = 3'b000,
  parameter int unsigned CE_WAIT  = 16,
  parameter int unsigned CLR_WAIT = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] req_div,
  output logic       req_ready,
  output logic       done,
  output logic       busy,
  output logic [3:0] cur_ratio,
  output logic       gt_ce,
  output logic       gt_cemask,
  output logic       gt_clr,
  output logic       gt_clrmask,
  output logic [2:0] gt_div
`ifdef BUFG_GT_DIV_CTRL_STATS_EN
  ,
  output logic [15:0] cfg_count,
  output logic        err_sticky
`endif
);

  localparam logic [CNT_W-1:0] CE_LOAD  = CNT_W'(CE_WAIT - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD = CNT_W'(CLR_WAIT - 1);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] pend_div;
  logic             accept;
  logic             tmr_load_n, tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_value_n, tmr_value;
  logic             ce_d, clr_d, done_d;

  assign gt_cemask  = 1'b0;
  assign gt_clrmask = 1'b0;

  // Reset re-arms the timer for the CLEAR state that startup begins in.
  assign tmr_load  = rst | tmr_load_n;
  assign tmr_value = rst ? CLR_LOAD : tmr_value_n;

  bufg_gt_ctrl_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  // Next state, timer load on entry to each timed state, next output values.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    tmr_load_n  = 1'b0;
    tmr_value_n = CLR_LOAD;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept      = 1'b1;
          state_d     = GATE;
          tmr_load_n  = 1'b1;
          tmr_value_n = CE_LOAD;
        end
      end
      GATE: begin
        if (tmr_zero) begin
          state_d     = CLEAR;
          tmr_load_n  = 1'b1;
          tmr_value_n = CLR_LOAD;
        end
      end
      CLEAR: begin
        if (tmr_zero) state_d = SETDIV;
      end
      SETDIV: begin
        state_d     = RELEASE;
        tmr_load_n  = 1'b1;
        tmr_value_n = CLR_LOAD;
      end
      RELEASE: begin
        if (tmr_zero) begin
          state_d     = ENABLE;
          tmr_load_n  = 1'b1;
          tmr_value_n = CE_LOAD;
        end
      end
      ENABLE: begin
        if (tmr_zero) state_d = IDLE;
      end
      default: begin
        state_d     = CLEAR;
        tmr_load_n  = 1'b1;
        tmr_value_n = CLR_LOAD;
      end
    endcase
    ce_d   = (state_d == IDLE) || (state_d == ENABLE);
    clr_d  = (state_d == CLEAR) || (state_d == SETDIV);
    done_d = (state_d == IDLE) && (state_q == ENABLE);
  end

  // State and registered outputs; gt_div only moves on entry to SETDIV.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      gt_ce     <= 1'b0;
      gt_clr    <= 1'b1;
      gt_div    <= INIT_DIV;
      pend_div  <= INIT_DIV;
      cur_ratio <= div2ratio(INIT_DIV);
      req_ready <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state_q   <= state_d;
      gt_ce     <= ce_d;
      gt_clr    <= clr_d;
      req_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      done      <= done_d;
      if (accept) pend_div <= req_div;
      if (state_d == SETDIV) begin
        gt_div    <= pend_div;
        cur_ratio <= div2ratio(pend_div);
      end
    end
  end

`ifdef BUFG_GT_DIV_CTRL_STATS_EN
  logic waiting_q;

  // Saturating completion count and sticky flag for a withdrawn request.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_count  <= 16'd0;
      err_sticky <= 1'b0;
      waiting_q  <= 1'b0;
    end else begin
      if (done_d && (cfg_count != 16'hFFFF)) cfg_count <= cfg_count + 16'd1;
      if (waiting_q && !req_valid) err_sticky <= 1'b1;
      waiting_q <= req_valid && !req_ready;
    end
  end
`endif

endmodule

// File: tb/tb_bufg_gt_div_ctrl.sv
// Directed bench for bufg_gt_div_ctrl: startup, table of divide changes, held and aborted requests.
module tb_bufg_gt_div_ctrl;
  import bufg_gt_div_ctrl_pkg::*;

  localparam int BUDGET = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_div = 3'b000;
  logic       req_ready, done, busy;
  logic [3:0] cur_ratio;
  logic       gt_ce, gt_cemask, gt_clr, gt_clrmask;
  logic [2:0] gt_div;
`ifdef BUFG_GT_DIV_CTRL_STATS_EN
  logic [15:0] cfg_count;
  logic        err_sticky;
`endif

  bufg_gt_div_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_div    (req_div),
    .req_ready  (req_ready),
    .done       (done),
    .busy       (busy),
    .cur_ratio  (cur_ratio),
    .gt_ce      (gt_ce),
    .gt_cemask  (gt_cemask),
    .gt_clr     (gt_clr),
    .gt_clrmask (gt_clrmask),
    .gt_div     (gt_div)
`ifdef BUFG_GT_DIV_CTRL_STATS_EN
    ,
    .cfg_count  (cfg_count),
    .err_sticky (err_sticky)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Protocol invariants watched on every falling edge outside reset.
  int         inv_errs = 0;
  logic [2:0] div_prev = 3'b000;
  logic       done_prev = 1'b0;
  always @(negedge clk) begin
    int e;
    e = 0;
    if (!rst) begin
      if (gt_ce && gt_clr) e++;
      if (gt_cemask || gt_clrmask) e++;
      if ((gt_div != div_prev) && !(gt_clr && !gt_ce)) e++;
      if (done && done_prev) e++;
    end
    inv_errs  <= inv_errs + e;
    div_prev  <= gt_div;
    done_prev <= done;
  end

  // Examine samples from the current one up to the done pulse, gathering timing.
  task automatic run_seq(output int lat, output int ce_low, output int clr_first,
                         output int clr_cnt, output int rdy_busy);
    int n;
    n = 0; ce_low = 0; clr_first = -1; clr_cnt = 0; rdy_busy = 0;
    while (1) begin
      if (!gt_ce) ce_low++;
      if (gt_clr) begin
        clr_cnt++;
        if (clr_first < 0) clr_first = n;
      end
      if (busy && req_ready) rdy_busy++;
      if (done || n >= BUDGET) break;
      tick();
      n++;
    end
    lat = done ? n : -1;
  endtask

  typedef struct {
    logic [2:0] div;
    int         ratio;
  } vec_t;

  vec_t vecs[6];
  int   lat, ce_low, clr_first, clr_cnt, rdy_busy;

  initial begin
    vecs[0] = '{div: DIV_1, ratio: 1};
    vecs[1] = '{div: DIV_4, ratio: 4};
    vecs[2] = '{div: DIV_4, ratio: 4};
    vecs[3] = '{div: DIV_8, ratio: 8};
    vecs[4] = '{div: DIV_6, ratio: 6};
    vecs[5] = '{div: DIV_2, ratio: 2};

    // Reset and startup
    rst = 1'b1;
    repeat (3) tick();
    check("rst_ce", int'(gt_ce), 0);
    check("rst_clr", int'(gt_clr), 1);
    check("rst_div", int'(gt_div), 0);
    check("rst_ready", int'(req_ready), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 1);
    rst = 1'b0;
    run_seq(lat, ce_low, clr_first, clr_cnt, rdy_busy);
    check("start_lat", lat, 49);
    check("start_ce_low", ce_low, 33);
    check("start_clr_cnt", clr_cnt, 17);
    check("start_ratio", int'(cur_ratio), 1);
    check("start_ready", int'(req_ready), 1);
`ifdef BUFG_GT_DIV_CTRL_STATS_EN
    check("start_cfg_count", int'(cfg_count), 1);
`endif
    tick();
    check("start_done_width", int'(done), 0);

    // Table of single divide changes; req_div is scrambled after acceptance
    foreach (vecs[i]) begin
      req_valid = 1'b1;
      req_div   = vecs[i].div;
      tick();
      req_valid = 1'b0;
      req_div   = ~vecs[i].div;
      check($sformatf("v%0d_busy", i), int'(busy), 1);
      run_seq(lat, ce_low, clr_first, clr_cnt, rdy_busy);
      check($sformatf("v%0d_lat", i), lat, 65);
      check($sformatf("v%0d_gate_len", i), clr_first, 16);
      check($sformatf("v%0d_clr_cnt", i), clr_cnt, 17);
      check($sformatf("v%0d_ce_low", i), ce_low, 49);
      check($sformatf("v%0d_ratio", i), int'(cur_ratio), vecs[i].ratio);
      check($sformatf("v%0d_div", i), int'(gt_div), int'(vecs[i].div));
      tick();
      check($sformatf("v%0d_done_width", i), int'(done), 0);
    end

    // Request held through a busy sequence is accepted on the done cycle
    req_valid = 1'b1;
    req_div   = DIV_3;
    tick();
    req_div = DIV_8;
    run_seq(lat, ce_low, clr_first, clr_cnt, rdy_busy);
    check("held_lat1", lat, 65);
    check("held_ready_busy", rdy_busy, 0);
    check("held_div1", int'(gt_div), 2);
    check("held_ratio1", int'(cur_ratio), 3);
    tick();
    req_valid = 1'b0;
    check("held_accepted", int'(busy), 1);
    run_seq(lat, ce_low, clr_first, clr_cnt, rdy_busy);
    check("held_lat2", lat, 65);
    check("held_ratio2", int'(cur_ratio), 8);
    tick();

    // Reset during RELEASE of a 3'b101 change drops the request
    req_valid = 1'b1;
    req_div   = DIV_6;
    tick();
    req_valid = 1'b0;
    repeat (40) tick();
    check("abort_in_release", int'({gt_ce, gt_clr}), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ce", int'(gt_ce), 0);
    check("abort_clr", int'(gt_clr), 1);
    check("abort_div", int'(gt_div), 0);
    check("abort_busy", int'(busy), 1);
    run_seq(lat, ce_low, clr_first, clr_cnt, rdy_busy);
    check("abort_lat", lat, 49);
    check("abort_ratio", int'(cur_ratio), 1);
    check("abort_div_final", int'(gt_div), 0);
`ifdef BUFG_GT_DIV_CTRL_STATS_EN
    check("abort_cfg_count", int'(cfg_count), 1);
    check("err_clear", int'(err_sticky), 0);
    req_valid = 1'b1;
    req_div   = DIV_2;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    req_valid = 1'b1;
    repeat (2) tick();
    req_valid = 1'b0;
    tick();
    check("err_set", int'(err_sticky), 1);
    run_seq(lat, ce_low, clr_first, clr_cnt, rdy_busy);
    check("err_cfg_count", int'(cfg_count), 2);
    check("err_still_set", int'(err_sticky), 1);
`endif
    tick();
    check("invariants", inv_errs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
